// File: rtl/receive_engine_if.sv
// Handshake/bus bundle for receive_engine: line, configuration, consumer read and status outputs.
interface receive_engine_if;
  logic [3:0] baud;
  logic       eight;
  logic       parity_en;
  logic       odd_n_even;
  logic       rx;
  logic       read;
  logic       rxrdy;
  logic [7:0] rdata;
  logic       perr;
  logic       ferr;
  logic       ovf;

  modport master (
    output baud, eight, parity_en, odd_n_even, rx, read,
    input  rxrdy, rdata, perr, ferr, ovf
  );

  modport slave (
    input  baud, eight, parity_en, odd_n_even, rx, read,
    output rxrdy, rdata, perr, ferr, ovf
  );
endinterface

// File: rtl/receive_engine.sv
// Asynchronous serial receiver: mid-bit sampling, 7/8 data bits, optional parity,
// framing/parity/overrun status with a one-cycle read pulse to acknowledge.
module receive_engine (
  input  logic           clk,
  input  logic           reset,
  receive_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_s, armed;
  logic [18:0] cnt, bit_k, half_k;
  logic        eight_q, par_q, odd_q;
  logic [3:0]  nbits, bit_idx;
  logic [8:0]  shreg, aligned;
  logic [7:0]  data_w;
  logic        pbit_w, perr_w;
  logic        cnt_clr, cfg_load, shift_en, complete;
  logic        rxrdy_q, perr_q, ferr_q, ovf_q;
  logic [7:0]  rdata_q;

  function automatic logic [18:0] baud_count(input logic [3:0] sel);
    case (sel)
      4'd0:    return 19'd333333;
      4'd1:    return 19'd83333;
      4'd2:    return 19'd41667;
      4'd3:    return 19'd20833;
      4'd4:    return 19'd10417;
      4'd5:    return 19'd5208;
      4'd6:    return 19'd2604;
      4'd7:    return 19'd1736;
      4'd8:    return 19'd868;
      4'd9:    return 19'd434;
      4'd10:   return 19'd217;
      default: return 19'd109;
    endcase
  endfunction

  assign half_k = bit_k >> 1;

  // Bits were shifted in from the top, so the frame sits left-aligned; bring it down.
  assign aligned = shreg >> (4'd9 - nbits);
  assign data_w  = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign pbit_w  = eight_q ? aligned[8] : aligned[7];
  assign perr_w  = par_q & (^data_w ^ pbit_w ^ odd_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cfg_load = 1'b0;
    shift_en = 1'b0;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (armed && !rx_s) begin
          state_n  = START;
          cfg_load = 1'b1;
        end
      end
      START: begin
        if (cnt == half_k - 19'd1) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == bit_k - 19'd1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == nbits - 4'd1) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == bit_k - 19'd1) begin
          cnt_clr  = 1'b1;
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      armed   <= 1'b0;
      cnt     <= '0;
      bit_k   <= 19'd109;
      eight_q <= 1'b0;
      par_q   <= 1'b0;
      odd_q   <= 1'b0;
      nbits   <= 4'd8;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      // A new start edge is only accepted after the line has been seen idle high.
      if (rx_s)          armed <= 1'b1;
      else if (complete) armed <= 1'b0;
      cnt <= cnt_clr ? '0 : cnt + 19'd1;
      if (cfg_load) begin
        bit_k   <= baud_count(bus.baud);
        eight_q <= bus.eight;
        par_q   <= bus.parity_en;
        odd_q   <= bus.odd_n_even;
        nbits   <= (bus.eight ? 4'd8 : 4'd7) + {3'b000, bus.parity_en};
        bit_idx <= '0;
      end
      if (shift_en) begin
        shreg   <= {rx_s, shreg[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxrdy_q <= 1'b0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (complete) begin
      rxrdy_q <= 1'b1;
      rdata_q <= data_w;
      perr_q  <= perr_w;
      ferr_q  <= ~rx_s;
      ovf_q   <= bus.read ? 1'b0 : (ovf_q | rxrdy_q);
    end else if (bus.read) begin
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign bus.rxrdy = rxrdy_q;
  assign bus.rdata = rdata_q;
  assign bus.perr  = perr_q;
  assign bus.ferr  = ferr_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_receive_engine.sv
// Bench for receive_engine: directed vector table, multi-cycle corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_receive_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  receive_engine_if bus ();
  receive_engine dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int unsigned KTAB [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                                        868, 434, 217, 109, 109, 109, 109, 109};

  int n_cmp = 0;
  int n_err = 0;
  bit m_rdy = 1'b0;
  bit m_ovf = 1'b0;

  typedef struct {
    logic [3:0] baud;
    bit         eight, par, odd;
    logic [7:0] data;
    bit         pbit, stop;
    logic [7:0] e_rdata;
    bit         e_perr, e_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h want 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] b, input bit e, input bit p, input bit o);
    bus.baud = b; bus.eight = e; bus.parity_en = p; bus.odd_n_even = o;
  endtask

  // Start bit, data bits LSB first, optional parity bit; optionally scramble config after the start bit.
  task automatic send_head(input int unsigned k, input logic [7:0] data, input bit eight,
                           input bit par, input bit pbit, input bit scramble);
    bus.rx = 1'b0;
    tick(k);
    if (scramble) begin
      bus.baud       = 4'($urandom_range(0, 15));
      bus.eight      = 1'($urandom);
      bus.parity_en  = 1'($urandom);
      bus.odd_n_even = 1'($urandom);
    end
    for (int i = 0; i < (eight ? 8 : 7); i++) begin
      bus.rx = data[i];
      tick(k);
    end
    if (par) begin
      bus.rx = pbit;
      tick(k);
    end
  endtask

  // Stop bit up to a few cycles past its center; rxrdy must be up by then.
  task automatic send_stop(input int unsigned k, input bit stop);
    bus.rx = stop;
    tick(k / 2 + 4);
  endtask

  task automatic finish_stop(input int unsigned k);
    tick(k - k / 2 - 4);
    bus.rx = 1'b1;
    tick(k);
  endtask

  function automatic bit model_perr(input logic [7:0] data, input bit eight, input bit par,
                                    input bit odd, input bit pbit);
    int ones;
    ones = $countones(eight ? data : (data & 8'h7F)) + int'(pbit);
    return par && ((ones % 2) != int'(odd));
  endfunction

  task automatic model_complete();
    m_ovf = m_ovf | m_rdy;
    m_rdy = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e_rdata, input bit e_perr, input bit e_ferr);
    check1({tag, ".rxrdy"}, bus.rxrdy, m_rdy);
    check8({tag, ".rdata"}, bus.rdata, e_rdata);
    check1({tag, ".perr"},  bus.perr,  e_perr);
    check1({tag, ".ferr"},  bus.ferr,  e_ferr);
    check1({tag, ".ovf"},   bus.ovf,   m_ovf);
  endtask

  task automatic do_read(input string tag);
    bus.read = 1'b1;
    tick(1);
    bus.read = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    check1({tag, ".rd_rxrdy"}, bus.rxrdy, 1'b0);
    check1({tag, ".rd_ovf"},   bus.ovf,   1'b0);
    check1({tag, ".rd_flags"}, bus.perr | bus.ferr, 1'b0);
  endtask

  task automatic simple_frame(input logic [7:0] data);
    set_cfg(4'd11, 1'b1, 1'b0, 1'b0);
    send_head(109, data, 1'b1, 1'b0, 1'b0, 1'b0);
    send_stop(109, 1'b1);
    model_complete();
  endtask

  initial begin
    int unsigned lat;
    bit          found;

    vecs[0] = '{4'd11, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{4'd11, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[2] = '{4'd11, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[3] = '{4'd11, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{4'd11, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{4'd12, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{4'd10, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{4'd15, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};

    reset = 1'b1;
    bus.rx = 1'b1;
    bus.read = 1'b0;
    set_cfg(4'd11, 1'b1, 1'b0, 1'b0);
    tick(3);
    check1("reset.rxrdy", bus.rxrdy, 1'b0);
    check8("reset.rdata", bus.rdata, 8'h00);
    check1("reset.flags", bus.perr | bus.ferr | bus.ovf, 1'b0);
    reset = 1'b0;
    tick(5);

    for (int v = 0; v < 8; v++) begin
      int unsigned k;
      k = KTAB[vecs[v].baud];
      set_cfg(vecs[v].baud, vecs[v].eight, vecs[v].par, vecs[v].odd);
      send_head(k, vecs[v].data, vecs[v].eight, vecs[v].par, vecs[v].pbit, 1'b0);
      send_stop(k, vecs[v].stop);
      model_complete();
      check_frame($sformatf("vec%0d", v), vecs[v].e_rdata, vecs[v].e_perr, vecs[v].e_ferr);
      finish_stop(k);
      do_read($sformatf("vec%0d", v));
    end

    // Overrun: two frames without a read.
    simple_frame(8'h11);
    finish_stop(109);
    simple_frame(8'h22);
    check_frame("ovr", 8'h22, 1'b0, 1'b0);
    finish_stop(109);
    do_read("ovr");

    // Measure stop-start to rxrdy latency, leave the frame unread, then land a read on completion.
    set_cfg(4'd11, 1'b1, 1'b0, 1'b0);
    send_head(109, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int c = 1; c <= 109; c++) begin
      tick(1);
      if (bus.rxrdy && !found) begin
        found = 1'b1;
        lat = c;
      end
    end
    check1("coinc.latency_found", found, 1'b1);
    model_complete();
    tick(109);
    if (found) begin
      send_head(109, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.rx = 1'b1;
      if (lat > 1) tick(lat - 1);
      bus.read = 1'b1;
      tick(1);
      bus.read = 1'b0;
      check1("coinc.rxrdy", bus.rxrdy, 1'b1);
      check1("coinc.ovf",   bus.ovf,   1'b0);
      check8("coinc.rdata", bus.rdata, 8'h44);
      m_rdy = 1'b1;
      m_ovf = 1'b0;
      tick(109);
    end
    do_read("coinc");

    // 20-cycle low glitch must be rejected as a false start.
    bus.rx = 1'b0;
    tick(20);
    bus.rx = 1'b1;
    tick(3 * 109);
    check1("glitch.rxrdy", bus.rxrdy, 1'b0);
    simple_frame(8'h96);
    check_frame("post_glitch", 8'h96, 1'b0, 1'b0);
    finish_stop(109);

    // Reset during data bits of 0xFF, with the previous frame still unread.
    bus.rx = 1'b0;
    tick(109);
    bus.rx = 1'b1;
    tick(3 * 109);
    #2 reset = 1'b1;
    #1;
    check1("rst_mid.rxrdy", bus.rxrdy, 1'b0);
    check8("rst_mid.rdata", bus.rdata, 8'h00);
    check1("rst_mid.flags", bus.perr | bus.ferr | bus.ovf, 1'b0);
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(7 * 109);
    check1("rst_mid.no_rdy", bus.rxrdy, 1'b0);
    simple_frame(8'h5A);
    check_frame("post_rst", 8'h5A, 1'b0, 1'b0);
    finish_stop(109);
    do_read("post_rst");

    // Randomized frames against the reference model, with mid-frame config scrambling.
    for (int r = 0; r < 16; r++) begin
      logic [3:0]  b;
      bit          e, p, o, pb, st;
      logic [7:0]  d, exp_d;
      int unsigned k;
      int          ones;
      b  = 4'($urandom_range(10, 15));
      e  = 1'($urandom);
      p  = 1'($urandom);
      o  = 1'($urandom);
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      exp_d = e ? d : {1'b0, d[6:0]};
      ones = $countones(exp_d);
      pb = 1'((ones % 2) ^ int'(o)) ^ ($urandom_range(0, 3) == 0);
      k  = KTAB[b];
      set_cfg(b, e, p, o);
      send_head(k, d, e, p, pb, 1'b1);
      send_stop(k, st);
      model_complete();
      check_frame($sformatf("rnd%0d", r), exp_d, model_perr(d, e, p, o, pb), !st);
      finish_stop(k);
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/receive_engine.md
RECEIVE_ENGINE -- requirements
Module: receive_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and reset; reset acts immediately without waiting for a clk edge.
REQ-002 clk  input  1  system clock, 100 MHz, rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 baud  input  4  baud-rate select, decoded per REQ-011.
REQ-005 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 parity_en  input  1  1 = a parity bit follows the data.
REQ-007 odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-008 rx  input  1  serial line; idles high; asynchronous to clk.
REQ-009 read  input  1  one-cycle pulse from the consumer that clears rxrdy and the error flags.
REQ-010 Outputs SHALL be:
- rxrdy  output  1  frame available.
- rdata  output  8  received byte.
- perr  output  1  parity error.
- ferr  output  1  framing error.
- ovf  output  1  overrun.

Function
REQ-011 The bit-time count k SHALL be selected by baud, in clk cycles:
- 0=333333, 1=83333, 2=41667, 3=20833
- 4=10417, 5=5208, 6=2604, 7=1736
- 8=868, 9=434, 10=217, 11=109
- 12..15 = 109
REQ-012 The half-bit count SHALL be k/2, truncated (for example 54 for k=109); counter width SHALL be 19 bits.
REQ-013 rx SHALL pass through a two-flop synchronizer with reset value 1 before any use.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE: a synchronized rx of 0 SHALL move the FSM to START and clear the counter.
REQ-016 START: after k/2 cycles, the FSM SHALL resample rx. If 0, go to DATA and clear the counter. If 1, treat it as a false start, return to IDLE and set no flags.
REQ-017 DATA: every k cycles the FSM SHALL sample rx into a right-shifting register, LSB first. The number of bits taken SHALL be (eight ? 8 : 7) + parity_en. The FSM then goes to STOP.
REQ-018 STOP: after k cycles, the FSM SHALL sample the stop bit and complete the frame in that same cycle, then return to IDLE.
REQ-019 On frame completion the block SHALL load:
- rdata with the data bits right-aligned; bit 7 = 0 when eight=0.
- ferr = (stop sample == 0).
REQ-020 On frame completion, perr SHALL be loaded as follows:
- If parity_en=1, perr = (XOR of data bits XOR parity bit XOR odd_n_even) != 0.
- If parity_en=0, perr = 0.
REQ-021 On frame completion, rxrdy SHALL be set to 1, and ovf SHALL be set if rxrdy was already 1 in that cycle.
REQ-022 rxrdy, perr, ferr and ovf SHALL clear the cycle after a read pulse.
REQ-023 If read and frame completion occur in the same cycle, completion SHALL win: new flags load, rxrdy=1, ovf=0.
REQ-024 ovf SHALL be sticky until read or reset; ovf SHALL NOT be cleared by a later completion.
REQ-025 baud, eight, parity_en and odd_n_even SHALL be sampled at the IDLE-to-START transition and held for the frame. Changes mid-frame SHALL NOT affect the frame in progress.
REQ-026 A frame with ferr=1 SHALL still set rxrdy and update rdata. The FSM SHALL return to IDLE and rearm only after rx is seen high.
REQ-027 rxrdy SHALL assert no later than 3 clk cycles after the nominal stop-bit center.

Reset
REQ-028 On reset the block SHALL set:
- FSM = IDLE; counter = 0; shift register = 0.
- synchronizer flops = 1.
- rdata = 0x00; rxrdy = 0, perr = 0, ferr = 0, ovf = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no flag or rdata update. After release, the block SHALL wait for a new falling edge on rx.

Verification
REQ-030 Bench SHALL cover: baud=11, 8N1, rx sends 0xA5 -> rdata=0xA5, rxrdy=1, perr=0, ferr=0, ovf=0; read pulse -> rxrdy=0 next cycle.
REQ-031 Bench SHALL cover: baud=11, 7 bits, even parity, data 0x41 with correct parity bit 0 -> rdata=0x41, perr=0. Repeat with the parity bit flipped -> perr=1, rdata=0x41.
REQ-032 Bench SHALL cover: baud=11, 8N1, byte 0x3C with stop bit driven 0 -> rxrdy=1, ferr=1, rdata=0x3C. Then rx high plus a new frame 0x01 is received correctly.
REQ-033 Bench SHALL cover: two frames 0x11 then 0x22 with no read in between -> rdata=0x22, ovf=1; read clears ovf. Also a read coincident with completion -> rxrdy=1, ovf=0.
REQ-034 Bench SHALL cover: a 20-cycle low glitch on rx at baud=11 -> no rxrdy, FSM back in IDLE.
REQ-035 Bench SHALL cover: reset pulsed during the DATA bits of 0xFF -> all outputs 0 and no rxrdy. Then a frame 0x5A sent after release -> rdata=0x5A.
